// File: rtl/fnorm_round.sv
// fnorm_round: post-addition normalize-and-round stage.
//
// This block takes the unnormalized sum from the align/add stage. The sum
// arrives as a sign, a biased exponent, and an extended mantissa:
//   {carry, hidden, fraction, guard, round, sticky}
// The block returns a packed IEEE-754 word. The pipeline is elastic and has
// three stages, with valid/ready handshaking on both sides.
//   S1: carry renormalize and leading-zero count
//   S2: left normalize, or clamp to the subnormal range
//   S3: round to nearest even, then pack
//
// Parameters
//   N           total word width; 32 or 64 only
//   EXP_W/MAN_W derived exponent and fraction widths
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake
//   in_sign, in_exp, in_mant   unnormalized sum
//   in_special, in_special_val bypass beat (zero/inf/NaN resolved upstream)
//   out_valid / out_ready      output handshake
//   out                        packed result {sign, exp, frac}
//   out_flags                  {overflow, underflow, inexact, zero}
//
// Build option
//   FNORM_FTZ_EN  When defined, any result that is subnormal before or after
//                 rounding is flushed to signed zero.
module fnorm_round #(
  parameter  int N     = 32,
  localparam int EXP_W = (N == 64) ? 11 : 8,
  localparam int MAN_W = (N == 64) ? 52 : 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+4:0] in_mant,
  input  logic             in_special,
  input  logic [N-1:0]     in_special_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out,
  output logic [3:0]       out_flags
);

  localparam int MSW = MAN_W + 3;          // hidden + fraction + guard + round
  localparam int LZW = $clog2(MSW + 1);
  localparam int XW  = EXP_W + 2;          // internal exponent, headroom for +1
  localparam int SW  = MAN_W + 2;          // rounded significand with carry-out

  // One advance strobe moves every stage together; bubbles move with it.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1
  logic [MSW-1:0] s1_mant_next;
  logic           s1_sticky_next;
  logic [XW-1:0]  s1_exp_next;
  logic [LZW-1:0] s1_lz_next;
  logic [MSW-1:0] s1_above_zero;

  // On a carry, shift right one place. The bit that falls out of round
  // joins sticky.
  always_comb begin
    if (in_mant[MAN_W+4]) begin
      s1_mant_next   = in_mant[MAN_W+4:2];
      s1_sticky_next = in_mant[1] | in_mant[0];
      s1_exp_next    = XW'(in_exp) + XW'(1);
    end else begin
      s1_mant_next   = in_mant[MAN_W+3:1];
      s1_sticky_next = in_mant[0];
      s1_exp_next    = XW'(in_exp);
    end
  end

  // Leading-zero count as a population count. Bit gi is set when every
  // position from the top down to gi is zero. After a carry shift the top
  // bit is 1, so the count is 0 automatically.
  genvar gi;
  generate
    for (gi = 0; gi < MSW; gi++) begin : g_lz
      assign s1_above_zero[gi] = ~|s1_mant_next[MSW-1:gi];
    end
  endgenerate

  always_comb begin
    s1_lz_next = '0;
    for (int i = 0; i < MSW; i++) begin
      s1_lz_next = s1_lz_next + LZW'(s1_above_zero[i]);
    end
  end

  logic           s1_valid_reg, s1_special_reg, s1_sign_reg;
  logic           s1_sticky_reg, s1_zero_reg;
  logic [N-1:0]   s1_special_val_reg;
  logic [XW-1:0]  s1_exp_reg;
  logic [MSW-1:0] s1_mant_reg;
  logic [LZW-1:0] s1_lz_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg       <= 1'b0;
      s1_special_reg     <= 1'b0;
      s1_sign_reg        <= 1'b0;
      s1_sticky_reg      <= 1'b0;
      s1_zero_reg        <= 1'b0;
      s1_special_val_reg <= '0;
      s1_exp_reg         <= '0;
      s1_mant_reg        <= '0;
      s1_lz_reg          <= '0;
    end else if (adv) begin
      s1_valid_reg       <= in_valid;
      s1_special_reg     <= in_special;
      s1_sign_reg        <= in_sign;
      s1_sticky_reg      <= s1_sticky_next;
      s1_zero_reg        <= (in_mant == '0);
      s1_special_val_reg <= in_special_val;
      s1_exp_reg         <= s1_exp_next;
      s1_mant_reg        <= s1_mant_next;
      s1_lz_reg          <= s1_lz_next;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [XW-1:0]  s2_shift_next, s2_exp_next;
  logic           s2_sub_next;
  logic [MSW-1:0] s2_mant_next;

  // Normalize as far as the exponent allows. If the leading one cannot
  // reach the hidden position, the value stays at the minimum exponent and
  // is encoded as a subnormal. Sticky stays in its own register, so zeros
  // fill from the right.
  always_comb begin
    s2_shift_next = XW'(s1_lz_reg);
    s2_sub_next   = 1'b0;
    if (s1_exp_reg == '0) begin
      s2_shift_next = '0;
      s2_sub_next   = 1'b1;
    end else if (XW'(s1_lz_reg) > s1_exp_reg - XW'(1)) begin
      s2_shift_next = s1_exp_reg - XW'(1);
      s2_sub_next   = 1'b1;
    end
    s2_mant_next = s1_mant_reg << s2_shift_next;
    s2_exp_next  = s2_sub_next ? '0 : s1_exp_reg - s2_shift_next;
  end

  logic           s2_valid_reg, s2_special_reg, s2_sign_reg;
  logic           s2_sticky_reg, s2_zero_reg, s2_sub_reg;
  logic [N-1:0]   s2_special_val_reg;
  logic [XW-1:0]  s2_exp_reg;
  logic [MSW-1:0] s2_mant_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg       <= 1'b0;
      s2_special_reg     <= 1'b0;
      s2_sign_reg        <= 1'b0;
      s2_sticky_reg      <= 1'b0;
      s2_zero_reg        <= 1'b0;
      s2_sub_reg         <= 1'b0;
      s2_special_val_reg <= '0;
      s2_exp_reg         <= '0;
      s2_mant_reg        <= '0;
    end else if (adv) begin
      s2_valid_reg       <= s1_valid_reg;
      s2_special_reg     <= s1_special_reg;
      s2_sign_reg        <= s1_sign_reg;
      s2_sticky_reg      <= s1_sticky_reg;
      s2_zero_reg        <= s1_zero_reg;
      s2_sub_reg         <= s2_sub_next;
      s2_special_val_reg <= s1_special_val_reg;
      s2_exp_reg         <= s2_exp_next;
      s2_mant_reg        <= s2_mant_next;
    end
  end

  // ---------------------------------------------------------------- S3
  logic             s3_guard, s3_round, s3_lsb, s3_round_up, s3_inexact;
  logic [SW-1:0]    s3_sum;
  logic [XW-1:0]    s3_exp;
  logic [MAN_W-1:0] s3_frac;
  logic [N-1:0]     out_next;
  logic [3:0]       flags_next;

  always_comb begin
    s3_guard    = s2_mant_reg[1];
    s3_round    = s2_mant_reg[0];
    s3_lsb      = s2_mant_reg[2];
    s3_round_up = s3_guard & (s3_round | s2_sticky_reg | s3_lsb);
    s3_inexact  = s3_guard | s3_round | s2_sticky_reg;
    s3_sum      = {1'b0, s2_mant_reg[MSW-1:2]} + SW'(s3_round_up);

    if (s3_sum[MAN_W+1]) begin
      // Carry past the hidden bit: the significand becomes 1.0 at exp+1.
      s3_exp  = s2_exp_reg + XW'(1);
      s3_frac = '0;
    end else begin
      s3_frac = s3_sum[MAN_W-1:0];
      // A subnormal that rounds up into the hidden bit becomes the
      // smallest normal.
      s3_exp  = s2_sub_reg ? XW'(s3_sum[MAN_W]) : s2_exp_reg;
    end

    out_next   = {s2_sign_reg, s3_exp[EXP_W-1:0], s3_frac};
    flags_next = {1'b0,
                  (s3_exp == '0) & s3_inexact,
                  s3_inexact,
                  (s3_exp == '0) && (s3_frac == '0)};

    if (s2_special_reg) begin
      out_next   = s2_special_val_reg;
      flags_next = 4'b0000;
    end else if (s2_zero_reg) begin
      out_next   = '0;
      flags_next = 4'b0001;
    end else if (s3_exp >= XW'((1 << EXP_W) - 1)) begin
      out_next   = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_next = 4'b1010;
    end
`ifdef FNORM_FTZ_EN
    else if (s2_sub_reg || (s3_exp == '0)) begin
      out_next   = {s2_sign_reg, {(N-1){1'b0}}};
      flags_next = 4'b0111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= s2_valid_reg;
      // Only real beats update the output word, so bubbles leave it quiet.
      if (s2_valid_reg) begin
        out       <= out_next;
        out_flags <= flags_next;
      end
    end
  end

endmodule

// File: tb/tb_fnorm_round.sv
`timescale 1ns/1ps
module tb_fnorm_round;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        in_special = 1'b0;
  logic [31:0] in_special_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  e;
    logic [27:0] m;
    logic        sp;
    logic [31:0] spv;
  } beat_t;

  logic [31:0] exp_out_q[$];
  logic [3:0]  exp_flag_q[$];

  fnorm_round #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_special(in_special), .in_special_val(in_special_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Reference model built from the arithmetic meaning of the fields.
  function automatic void model(input beat_t b, output logic [31:0] r, output logic [3:0] f);
    logic [63:0] y;
    logic [24:0] sig;
    logic        g, rr, s, up, inx, sub;
    int          p, lzv, ev, e, sh;
    r = '0;
    f = '0;
    if (b.sp) begin
      r = b.spv;
      return;
    end
    if (b.m == '0) begin
      f = 4'b0001;
      return;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (b.m[i]) p = i;
    ev  = int'(b.e);
    sub = 1'b0;
    if (p == 27) begin
      y = {36'b0, b.m} >> 1;
      s = b.m[1] | b.m[0];
      e = ev + 1;
    end else begin
      lzv = 26 - p;
      s   = b.m[0];
      if (ev == 0) begin
        sh = 0; sub = 1'b1; e = 0;
      end else if (lzv > ev - 1) begin
        sh = ev - 1; sub = 1'b1; e = 0;
      end else begin
        sh = lzv; e = ev - lzv;
      end
      y = ({36'b0, b.m} & ~64'd1) << sh;
    end
    g   = y[2];
    rr  = y[1];
    inx = g | rr | s;
    up  = g & (rr | s | y[3]);
    sig = {1'b0, y[26:3]} + {24'b0, up};
    if (sig[24]) begin
      sig = 25'h0800000;
      e   = e + 1;
    end else if (sub && sig[23]) begin
      e = 1;
    end
    if (e >= 255) begin
      r = {b.sign, 8'hFF, 23'b0};
      f = 4'b1010;
      return;
    end
`ifdef FNORM_FTZ_EN
    if (sub || e == 0) begin
      r = {b.sign, 31'b0};
      f = 4'b0111;
      return;
    end
`endif
    r = {b.sign, 8'(e), sig[22:0]};
    f = {1'b0, (e == 0) & inx, inx, (e == 0) && (sig[22:0] == 0)};
  endfunction

  function automatic beat_t rand_beat();
    beat_t       b;
    logic [27:0] m;
    b.sign = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       b.e = 8'($urandom_range(0, 30));
      1:       b.e = 8'($urandom_range(250, 254));
      default: b.e = 8'($urandom_range(1, 254));
    endcase
    m = 28'($urandom);
    case ($urandom_range(0, 3))
      0:       m[27] = 1'b1;
      1:       m[27:26] = 2'b01;
      default: begin m[27] = 1'b0; m = m >> $urandom_range(0, 27); end
    endcase
    b.m   = m;
    b.sp  = ($urandom_range(0, 7) == 0);
    b.spv = $urandom;
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    in_sign        = b.sign;
    in_exp         = b.e;
    in_mant        = b.m;
    in_special     = b.sp;
    in_special_val = b.spv;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 00000000", out); end
    checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", out_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    beat_t       b[10];
    logic [31:0] er[10];
    logic [3:0]  ef[10];
    logic [31:0] wr;
    logic [3:0]  wf;
    int sent = 0, got = 0, cyc = 0, acc0 = -1;
    b[0] = '{1'b0, 8'h7F, 28'hA000000, 1'b0, 32'h0}; er[0] = 32'h40200000; ef[0] = 4'b0000;
    b[1] = '{1'b0, 8'h7F, 28'h4000004, 1'b0, 32'h0}; er[1] = 32'h3F800000; ef[1] = 4'b0010;
    b[2] = '{1'b0, 8'h7F, 28'h400000C, 1'b0, 32'h0}; er[2] = 32'h3F800002; ef[2] = 4'b0010;
    b[3] = '{1'b1, 8'h85, 28'h0000000, 1'b0, 32'h0}; er[3] = 32'h00000000; ef[3] = 4'b0001;
    b[4] = '{1'b0, 8'hFE, 28'h8000000, 1'b0, 32'h0}; er[4] = 32'h7F800000; ef[4] = 4'b1010;
    b[5] = '{1'b0, 8'h01, 28'h2000000, 1'b0, 32'h0};
    b[6] = '{1'b1, 8'h55, 28'h0000123, 1'b1, 32'h7FC00000}; er[6] = 32'h7FC00000; ef[6] = 4'b0000;
    b[7] = '{1'b0, 8'h80, 28'h1000000, 1'b0, 32'h0}; er[7] = 32'h3F000000; ef[7] = 4'b0000;
    b[8] = '{1'b0, 8'h01, 28'h2000005, 1'b0, 32'h0};
    b[9] = '{1'b0, 8'h01, 28'h3FFFFFC, 1'b0, 32'h0};
`ifdef FNORM_FTZ_EN
    er[5] = 32'h00000000; ef[5] = 4'b0111;
    er[8] = 32'h00000000; ef[8] = 4'b0111;
    er[9] = 32'h00000000; ef[9] = 4'b0111;
`else
    er[5] = 32'h00400000; ef[5] = 4'b0000;
    er[8] = 32'h00400001; ef[8] = 4'b0110;
    er[9] = 32'h00800000; ef[9] = 4'b0010;
`endif
    exp_out_q.delete();
    exp_flag_q.delete();
    out_ready = 1'b1;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      if (sent < 10) begin drive_beat(b[sent]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        if (exp_out_q.size() == 0) begin
          checks++; errors++; $display("FAIL directed_spurious got %h want none", out);
        end else begin
          wr = exp_out_q.pop_front();
          wf = exp_flag_q.pop_front();
          checks++;
          if (out !== wr || out_flags !== wf) begin
            errors++;
            $display("FAIL directed_%0d got %h/%b want %h/%b", got, out, out_flags, wr, wf);
          end
          if (got == 0) begin
            checks++;
            if (cyc != acc0 + 3) begin errors++; $display("FAIL latency got %0d want %0d", cyc - acc0, 3); end
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_out_q.push_back(er[sent]);
        exp_flag_q.push_back(ef[sent]);
        if (sent == 0) acc0 = cyc;
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 10) begin errors++; $display("FAIL directed_count got %0d want 10", got); end
  endtask

  task automatic test_random();
    beat_t       b;
    logic [31:0] wr;
    logic [3:0]  wf;
    int sent = 0, got = 0, cyc = 0;
    exp_out_q.delete();
    exp_flag_q.delete();
    b = rand_beat();
    while (got < 40 && cyc < 2000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      if (sent < 40 && $urandom_range(0, 9) < 7) begin drive_beat(b); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) begin
          checks++; errors++; $display("FAIL random_spurious got %h want none", out);
        end else begin
          wr = exp_out_q.pop_front();
          wf = exp_flag_q.pop_front();
          checks++;
          if (out !== wr || out_flags !== wf) begin
            errors++;
            $display("FAIL random_%0d got %h/%b want %h/%b", got, out, out_flags, wr, wf);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        model(b, wr, wf);
        exp_out_q.push_back(wr);
        exp_flag_q.push_back(wf);
        sent++;
        b = rand_beat();
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 40) begin errors++; $display("FAIL random_count got %0d want 40", got); end
  endtask

  task automatic test_backpressure();
    beat_t       barr[6];
    logic [31:0] wr, held;
    logic [3:0]  wf, heldf;
    logic        stall_prev = 1'b0;
    int sent = 0, got = 0;
    for (int k = 0; k < 6; k++) begin
      barr[k] = rand_beat();
      barr[k].sp = 1'b0;
      barr[k].e  = 8'(8'h70 + k);
    end
    held  = '0;
    heldf = '0;
    exp_out_q.delete();
    exp_flag_q.delete();
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = (((cyc / 2) % 2) == 1);
      if (sent < 6) begin drive_beat(barr[sent]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out !== held || out_flags !== heldf) begin
          errors++;
          $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b", out_valid, out, out_flags, held, heldf);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_spurious got %h want none", out);
        end else begin
          wr = exp_out_q.pop_front();
          wf = exp_flag_q.pop_front();
          checks++;
          if (out !== wr || out_flags !== wf) begin
            errors++;
            $display("FAIL bp_%0d got %h/%b want %h/%b", got, out, out_flags, wr, wf);
          end
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held       = out;
      heldf      = out_flags;
      if (in_valid && in_ready) begin
        model(barr[sent], wr, wf);
        exp_out_q.push_back(wr);
        exp_flag_q.push_back(wf);
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got); end
  endtask

  task automatic test_reset_midflight();
    beat_t b;
    int    seen = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b = rand_beat();
      drive_beat(b);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", out_valid); end
    checks++; if (out !== 32'h0 || out_flags !== 4'h0) begin errors++; $display("FAIL async_rst_data got %h/%b want 00000000/0000", out, out_flags); end
    exp_out_q.delete();
    exp_flag_q.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    b = '{1'b0, 8'h7F, 28'h400000C, 1'b0, 32'h0};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin drive_beat(b); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (c == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", in_ready); end
      end
      if (out_valid) begin
        seen++;
        checks++;
        if (c != 3 || out !== 32'h3F800002 || out_flags !== 4'b0010) begin
          errors++;
          $display("FAIL post_rst_result got cyc%0d %h/%b want cyc3 3f800002/0010", c, out, out_flags);
        end
      end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL post_rst_count got %0d want 1", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnorm_round.md
# fnorm_round

Post-addition normalize-and-round stage for the floating-point datapath. It consumes the unnormalized sum produced by the `fadd` exponent-align/add stage: sign, pre-adjust biased exponent, and an extended mantissa with carry, hidden, guard, round and sticky bits. It produces a packed IEEE-754 result in the same format width. It is a 3-stage elastic pipeline with valid/ready handshaking and round-to-nearest-even rounding.

## Interface
- `N`, default 32, total word width; only 32 (`EXP_W`=8, `MAN_W`=23) or 64 (`EXP_W`=11, `MAN_W`=52) are legal; `EXP_W`/`MAN_W` are derived localparams.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage can accept; equals `~out_valid | out_ready` (combinational).
- `in_sign`  in  1  sign of sum.
- `in_exp`  in  `EXP_W`  biased exponent of the larger operand (0 to 2^`EXP_W`-2).
- `in_mant`  in  `MAN_W`+5  mantissa bit layout:
  - [`MAN_W`+4] carry
  - [`MAN_W`+3] hidden
  - [`MAN_W`+2:3] fraction
  - [2] guard
  - [1] round
  - [0] sticky
- `in_special`  in  1  bypass: emit `in_special_val` unchanged (zero/inf/NaN operands resolved upstream).
- `in_special_val`  in  N  bypass result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out`  out  N  packed result {sign, exp, frac}.
- `out_flags`  out  4  {overflow, underflow, inexact, zero}.

## Operation
- Transfer happens when valid & ready on the same edge. A global advance signal `adv = ~out_valid | out_ready` enables all three stage registers together; bubbles advance with it.
- S1 (classify/LZC):
  - If carry=1: shift mantissa right 1, OR the shifted-out bit into sticky, exp+1.
  - Else: count leading zeros `lz` from the hidden bit over hidden+fraction+G+R.
  - Mantissa all zero (incl. G/R/S) → zero-result flag.
- S2 (normalize):
  - `shift = min(lz, in_exp-1)` when in_exp≥1, else 0.
  - Shift left by `shift`; exp -= shift.
  - If `lz > in_exp-1`, the result is subnormal: exp field = 0.
  - Sticky is never shifted left into the result; zeros fill.
- S3 (round/pack):
  - `round_up = G & (R | S | lsb)`; fraction+hidden += round_up.
  - Rounding carry out of the hidden bit → exp+1, fraction = 0.
  - A subnormal rounding into the hidden bit becomes exp field 1.
  - exp ≥ 2^`EXP_W`-1 after adjust → ±infinity; overflow=1, inexact=1.
  - Exact cancellation (zero mantissa) → +0, zero=1, all other flags 0.
  - inexact = G|R|S after normalization.
  - underflow = result subnormal or zero (non-cancellation) and inexact.
  - Zero flag is also set when a rounded result is ±0.
- Special bypass: the `in_special_val` beat travels the same 3 stages unchanged; flags = 0.
- Output order equals input order; no beat is dropped or duplicated.

## Timing
- Latency: 3 `adv` cycles from accepted input to `out_valid`. Throughput is 1 beat/cycle when `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, all stages hold, `in_ready`=0, and `out`/`out_flags` are stable.
- Reset (async assert, any time, including mid-operation):
  - All stage valids, `out_valid`, `out` and `out_flags` go to 0 immediately.
  - In-flight beats are discarded.
  - Reset release is synchronized by the system; the first accept is possible on the first edge after deassertion.
- `in_ready` has no dependency on `in_valid`; `out_valid` has no combinational dependency on `out_ready`.

## Configuration
- `FNORM_FTZ_EN` defined: any result that would be subnormal, before or after rounding, is flushed to signed zero (sign = `in_sign`), with underflow=1, inexact=1, zero=1.
- `FNORM_FTZ_EN` undefined: full gradual-underflow behaviour as described in Operation.

## Test plan
All vectors use N=32, `out_ready`=1 unless stated.
- Carry normalize: `in_exp`=0x7F, carry=1, hidden=0, fraction MSB=1, G/R/S=0 → after 3 cycles `out`=0x40200000, flags=0000.
- Round-to-even: `in_exp`=0x7F, hidden=1, frac=0, G=1 → `out`=0x3F800000, inexact=1. Same with frac=1 → 0x3F800002.
- Cancellation and overflow:
  - `in_mant`=0, `in_exp`=0x85, sign=1 → 0x00000000, zero=1.
  - `in_exp`=0xFE, carry=1 → 0x7F800000 (sign 0), overflow=1, inexact=1.
- Subnormal: `in_exp`=1, hidden=0, fraction MSB=1 → 0x00400000, flags=0000. With `FNORM_FTZ_EN` → 0x00000000, flags=0111.
- Backpressure: stream 6 distinct beats while toggling `out_ready` 0/1 every 2 cycles → all 6 results emerge in order, values match the reference model, and `out` holds stable while stalled.
- Reset mid-flight: assert `rst_n`=0 with 3 beats in flight → `out_valid`=0 at once. After release, one new beat gives exactly one result 3 cycles later.
